// File: rtl/wb_pkg.sv
// Shared encodings for the write-back data selector: extraction modes and helpers.
package wb_pkg;

    typedef enum logic [2:0] {
        WORD   = 3'b000,
        BYTE_S = 3'b001,
        BYTE_U = 3'b010,
        HALF_S = 3'b011,
        HALF_U = 3'b100
    } ext_mode_t;

    localparam logic [2:0] EXT_WORD   = WORD;
    localparam logic [2:0] EXT_BYTE_S = BYTE_S;
    localparam logic [2:0] EXT_BYTE_U = BYTE_U;
    localparam logic [2:0] EXT_HALF_S = HALF_S;
    localparam logic [2:0] EXT_HALF_U = HALF_U;

    function automatic logic is_half(input logic [2:0] mode);
        return (mode == EXT_HALF_S) || (mode == EXT_HALF_U);
    endfunction

endpackage

// File: rtl/wb_extend.sv
// Combinational sub-word extractor: little-endian byte/halfword pick with sign/zero extension.
module wb_extend
    import wb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] word,
    input  logic [2:0]        mode,
    input  logic [1:0]        off,
    output logic [DATA_W-1:0] data,
    output logic              misalign
);

    logic [7:0]  byt;
    logic [15:0] half;

    always_comb begin
        byt  = word[{off, 3'b000} +: 8];
        half = word[{off[1], 4'b0000} +: 16];
        case (mode)
            EXT_BYTE_S: data = {{(DATA_W-8){byt[7]}}, byt};
            EXT_BYTE_U: data = {{(DATA_W-8){1'b0}}, byt};
            EXT_HALF_S: data = {{(DATA_W-16){half[15]}}, half};
            EXT_HALF_U: data = {{(DATA_W-16){1'b0}}, half};
            default:    data = word;
        endcase
    end

    // Halfword extraction ignores off[0]; an odd offset is reported, not corrected.
    assign misalign = is_half(mode) && off[0];

endmodule

// File: rtl/wb_data_sel.sv
// Registered write-back selector: source mux + extension feeding a main/skid
// register pair so that in_ready never depends combinationally on out_ready.
module wb_data_sel
    import wb_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int NUM_SRC = 8,
    parameter int SEL_W   = $clog2(NUM_SRC)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic [SEL_W-1:0]          sel,
    input  logic [2:0]                ext_mode,
    input  logic [1:0]                byte_off,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_err
);

    localparam int NSLOT = 1 << SEL_W;

    // Slots past NUM_SRC read as zero so the mux index never leaves the array.
    logic [NSLOT-1:0][DATA_W-1:0] srcs;
    genvar gi;
    generate
        for (gi = 0; gi < NSLOT; gi++) begin : g_src
            if (gi < NUM_SRC) begin : g_real
                assign srcs[gi] = src_data[gi*DATA_W +: DATA_W];
            end else begin : g_pad
                assign srcs[gi] = '0;
            end
        end
    endgenerate

    logic              sel_oor, misalign;
    logic [DATA_W-1:0] ext_data, new_data;
    logic              new_err;

    assign sel_oor = 32'(sel) >= NUM_SRC;

    wb_extend #(.DATA_W(DATA_W)) u_ext (
        .word     (srcs[sel]),
        .mode     (ext_mode),
        .off      (byte_off),
        .data     (ext_data),
        .misalign (misalign)
    );

    assign new_data = sel_oor ? '0 : ext_data;
    assign new_err  = sel_oor | misalign;

    logic [DATA_W-1:0] m_data, m_data_n, s_data, s_data_n;
    logic              m_err, m_err_n, s_err, s_err_n;
    logic              m_valid, m_valid_n, s_valid, s_valid_n;
    logic              rdy_q;
    logic              in_xfer, out_xfer;

    assign in_xfer  = in_valid && rdy_q;
    assign out_xfer = m_valid && out_ready;

    always_comb begin
        m_data_n  = m_data;
        m_err_n   = m_err;
        m_valid_n = m_valid;
        s_data_n  = s_data;
        s_err_n   = s_err;
        s_valid_n = s_valid;
        if (out_xfer) begin
            if (s_valid) begin
                m_data_n  = s_data;
                m_err_n   = s_err;
                s_valid_n = 1'b0;
            end else begin
                m_valid_n = 1'b0;
            end
        end
        // in_xfer implies S empty, so a draining M can always take the new entry.
        if (in_xfer) begin
            if (!m_valid || out_xfer) begin
                m_data_n  = new_data;
                m_err_n   = new_err;
                m_valid_n = 1'b1;
            end else begin
                s_data_n  = new_data;
                s_err_n   = new_err;
                s_valid_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_data  <= '0;
            m_err   <= 1'b0;
            m_valid <= 1'b0;
            s_data  <= '0;
            s_err   <= 1'b0;
            s_valid <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            m_data  <= m_data_n;
            m_err   <= m_err_n;
            m_valid <= m_valid_n;
            s_data  <= s_data_n;
            s_err   <= s_err_n;
            s_valid <= s_valid_n;
            rdy_q   <= !s_valid_n;
        end
    end

    // rdy_q mirrors !s_valid out of reset but holds low while reset is asserted.
    assign in_ready  = rdy_q;
    assign out_data  = m_data;
    assign out_err   = m_err;
    assign out_valid = m_valid;

endmodule

// File: tb/tb_wb_data_sel.sv
// Directed bench for wb_data_sel: scoreboard-checked output stream plus point checks.
module tb_wb_data_sel;
    import wb_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [8*32-1:0] src_data;
    logic [2:0]      sel, ext_mode;
    logic [1:0]      byte_off;
    logic            in_valid, in_ready, out_valid, out_ready, out_err;
    logic [31:0]     out_data;

    logic [6*32-1:0] src_data6;
    logic [2:0]      sel6, ext_mode6;
    logic [1:0]      byte_off6;
    logic            in_valid6, in_ready6, out_valid6, out_ready6, out_err6;
    logic [31:0]     out_data6;

    wb_data_sel #(.DATA_W(32), .NUM_SRC(8)) dut (
        .clk(clk), .reset(reset), .src_data(src_data), .sel(sel),
        .ext_mode(ext_mode), .byte_off(byte_off), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_err(out_err)
    );

    wb_data_sel #(.DATA_W(32), .NUM_SRC(6)) dut6 (
        .clk(clk), .reset(reset), .src_data(src_data6), .sel(sel6),
        .ext_mode(ext_mode6), .byte_off(byte_off6), .in_valid(in_valid6),
        .in_ready(in_ready6), .out_data(out_data6), .out_valid(out_valid6),
        .out_ready(out_ready6), .out_err(out_err6)
    );

    typedef struct { logic [31:0] d; logic e; } exp_t;
    exp_t q[$];
    int checks = 0, passes = 0, fails = 0, outs = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output transfers happen at the next rising edge; outputs are stable here.
    always begin : monitor
        exp_t e;
        @(negedge clk);
        #1;
        if (reset && out_valid && out_ready) begin
            outs++;
            if (q.size() == 0) check("unexpected_output", 64'(out_data), 64'hDEAD);
            else begin
                e = q.pop_front();
                check("sb_data", 64'(out_data), 64'(e.d));
                check("sb_err", 64'(out_err), 64'(e.e));
            end
        end
    end

    task automatic drive(input logic [2:0] s, input logic [2:0] m, input logic [1:0] o);
        sel = s; ext_mode = m; byte_off = o; in_valid = 1'b1;
    endtask

    task automatic send(input logic [2:0] s, input logic [2:0] m, input logic [1:0] o,
                        input logic [31:0] ed, input logic ee);
        int n;
        exp_t e;
        drive(s, m, o);
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("send_timeout", 64'(in_ready), 64'd1);
        else begin
            e.d = ed; e.e = ee;
            q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        in_valid = 1'b0;
        while (q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check(tag, 64'(q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int outs0;
        src_data = '0;
        for (int i = 0; i < 8; i++) src_data[i*32 +: 32] = 32'h1111_1111 * i;
        src_data[1*32 +: 32] = 32'h0000_80F0;
        src_data[2*32 +: 32] = 32'h1234_5678;
        src_data[3*32 +: 32] = 32'hABCD_1234;
        for (int i = 0; i < 6; i++) src_data6[i*32 +: 32] = 32'hC0DE_0000 + 32'(i);
        sel = '0; ext_mode = EXT_WORD; byte_off = '0; in_valid = 1'b0; out_ready = 1'b1;
        sel6 = '0; ext_mode6 = EXT_WORD; byte_off6 = '0; in_valid6 = 1'b0; out_ready6 = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_err", 64'(out_err), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Single word, one-cycle latency.
        send(3'd2, EXT_WORD, 2'd0, 32'h1234_5678, 1'b0);
        in_valid = 1'b0;
        check("lat_out_valid", 64'(out_valid), 64'd1);
        check("lat_out_data", 64'(out_data), 64'h1234_5678);
        check("lat_out_err", 64'(out_err), 64'd0);
        drain("drain_word");

        // Back-to-back extraction modes.
        send(3'd1, EXT_BYTE_S, 2'd0, 32'hFFFF_FFF0, 1'b0);
        send(3'd1, EXT_BYTE_U, 2'd0, 32'h0000_00F0, 1'b0);
        send(3'd1, EXT_HALF_S, 2'd0, 32'hFFFF_80F0, 1'b0);
        send(3'd1, EXT_HALF_U, 2'd2, 32'h0000_0000, 1'b0);
        send(3'd1, EXT_BYTE_S, 2'd1, 32'hFFFF_FF80, 1'b0);
        send(3'd2, EXT_BYTE_U, 2'd3, 32'h0000_0012, 1'b0);
        send(3'd3, EXT_HALF_S, 2'd2, 32'hFFFF_ABCD, 1'b0);
        send(3'd3, EXT_HALF_S, 2'd1, 32'h0000_1234, 1'b1);
        send(3'd1, EXT_HALF_U, 2'd3, 32'h0000_0000, 1'b1);
        send(3'd2, 3'b110, 2'd1, 32'h1234_5678, 1'b0);
        drain("drain_modes");

        // Select range on the six-source instance.
        check("d6_in_ready", 64'(in_ready6), 64'd1);
        sel6 = 3'd7; in_valid6 = 1'b1;
        @(negedge clk);
        sel6 = 3'd5;
        check("oor7_valid", 64'(out_valid6), 64'd1);
        check("oor7_data", 64'(out_data6), 64'd0);
        check("oor7_err", 64'(out_err6), 64'd1);
        @(negedge clk);
        sel6 = 3'd6;
        check("sel5_data", 64'(out_data6), 64'hC0DE_0005);
        check("sel5_err", 64'(out_err6), 64'd0);
        @(negedge clk);
        in_valid6 = 1'b0;
        check("oor6_data", 64'(out_data6), 64'd0);
        check("oor6_err", 64'(out_err6), 64'd1);

        // Back-pressure: A,B,C,D with out_ready low for two cycles.
        out_ready = 1'b1;
        drive(3'd2, EXT_WORD, 2'd0);
        check("bp_a_ready", 64'(in_ready), 64'd1);
        e.d = 32'h1234_5678; e.e = 1'b0; q.push_back(e);
        @(negedge clk);
        drive(3'd3, EXT_WORD, 2'd0);
        e.d = 32'hABCD_1234; e.e = 1'b0; q.push_back(e);
        out_ready = 1'b0;
        @(negedge clk);
        check("bp_inrdy_low1", 64'(in_ready), 64'd0);
        check("bp_stable1", 64'(out_data), 64'h1234_5678);
        drive(3'd1, EXT_BYTE_U, 2'd0);
        @(negedge clk);
        check("bp_inrdy_low2", 64'(in_ready), 64'd0);
        check("bp_stable2", 64'(out_data), 64'h1234_5678);
        check("bp_valid_hold", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_inrdy_back", 64'(in_ready), 64'd1);
        check("bp_b_in_m", 64'(out_data), 64'hABCD_1234);
        e.d = 32'h0000_00F0; e.e = 1'b0; q.push_back(e);
        @(negedge clk);
        drive(3'd5, EXT_WORD, 2'd0);
        e.d = 32'h5555_5555; e.e = 1'b0; q.push_back(e);
        @(negedge clk);
        drain("drain_bp");

        // Reset while both registers hold entries.
        out_ready = 1'b0;
        send(3'd6, EXT_WORD, 2'd0, 32'h6666_6666, 1'b0);
        send(3'd4, EXT_WORD, 2'd0, 32'h4444_4444, 1'b0);
        in_valid = 1'b0;
        check("full_in_ready", 64'(in_ready), 64'd0);
        check("full_out_valid", 64'(out_valid), 64'd1);
        #3 reset = 1'b0;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_data", 64'(out_data), 64'd0);
        check("mid_rst_err", 64'(out_err), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd0);
        q.delete();
        outs0 = outs;
        @(negedge clk);
        reset = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("rerst_in_ready", 64'(in_ready), 64'd1);
        send(3'd3, EXT_HALF_U, 2'd2, 32'h0000_ABCD, 1'b0);
        drain("drain_e");
        repeat (3) @(negedge clk);
        check("e_alone", 64'(outs - outs0), 64'd1);
        check("idle_valid", 64'(out_valid), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/wb_data_sel.md
# wb_data_sel

Parametrised, registered write-back data selector for the multi-cycle CPU datapath. Picks one of `NUM_SRC` source words (memory load, ALUOut, shift, HI, LO, LT, …), applies byte/halfword extraction with sign/zero extension, and delivers the result to the register-file write port through a valid/ready handshake backed by a one-entry skid buffer. Out-of-range selects and misaligned halfwords are flagged instead of producing undefined data.

## Interface
Parameters:
- `DATA_W`, 32: width of each source word and of the output.
- `NUM_SRC`, 8: number of sources; any value ≥ 2.
- `SEL_W`, `$clog2(NUM_SRC)`: select width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `src_data`  in  `NUM_SRC*DATA_W`  flattened sources; source i is bits `[i*DATA_W +: DATA_W]`.
- `sel`  in  `SEL_W`  source index.
- `ext_mode`  in  3  extraction mode, encodings in the package.
- `byte_off`  in  2  byte offset within the word for sub-word modes.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  block can accept a request this cycle.
- `out_data`  out  `DATA_W`  selected and extended word.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  consumer accepts `out_data` this cycle.
- `out_err`  out  1  travels with `out_data`: select out of range or misaligned halfword.

## Operation
- Input transfer occurs when `in_valid && in_ready`. Output transfer occurs when `out_valid && out_ready`.
- Datapath result is combinational from `src_data`, `sel`, `ext_mode`, and `byte_off`. It is captured only on an input transfer.
- Modes:
  - WORD 3'b000: word unchanged.
  - BYTE_S 3'b001: byte at `byte_off`, sign-extended.
  - BYTE_U 3'b010: byte at `byte_off`, zero-extended.
  - HALF_S 3'b011: halfword at `byte_off[1]`, sign-extended.
  - HALF_U 3'b100: halfword at `byte_off[1]`, zero-extended.
  - Codes 101–111 are treated as WORD.
- Byte lanes are little-endian: `byte_off=0` selects bits [7:0].
- Halfword modes ignore `byte_off[0]` for extraction. `byte_off[0]=1` in a halfword mode sets `out_err`; data is still the extracted halfword.
- `sel ≥ NUM_SRC`: data forced to 0 and `out_err=1`.
- Storage is a main register (M) and a skid register (S), each holding data, err, and a valid bit.
  - `out_*` always reflect M.
  - `in_ready = !S.valid`, driven directly from the S valid flop.
- Per-cycle update on an input transfer:
  - If M is empty, or M is being output-transferred this cycle, the new entry goes to M.
  - Otherwise the new entry goes to S.
- On an output transfer with S full, S moves to M and S empties.
- Order is strictly FIFO. No entry is dropped or duplicated.
- Reset (async assert, any time): `out_valid=0`, `out_data=0`, `out_err=0`, S cleared, `in_ready=0` while reset is asserted and 1 from the first edge after deassert. Entries in flight are discarded.

## Timing
- Latency: an input transfer at edge N gives `out_valid=1` after edge N, provided M was empty or drained at N.
- Throughput: 1 transfer/cycle when `out_ready` is held high.
- `out_ready` low for one cycle with continuous input:
  - the first blocked word lands in S;
  - `in_ready` drops the next cycle;
  - `in_ready` recovers one cycle after `out_ready` returns.
- No combinational path from `out_ready` to `in_ready`.
- `out_data`/`out_err` stay stable while `out_valid && !out_ready`.
- Simultaneous input and output transfer with S empty: M is overwritten with the new entry and `out_valid` stays 1.

## Structure
- Package `wb_pkg`: `ext_mode_t` enum (WORD, BYTE_S, BYTE_U, HALF_S, HALF_U) and the `EXT_*` localparam encodings.
- Sub-module `wb_extend`: combinational extractor, inputs word, mode, and offset; outputs data and misalign flag. Instantiated once.
- Top level holds the source mux, out-of-range check, and the M/S skid buffer.

## Test plan
- Default params, `out_ready=1`:
  - `sel=2`, src2=0x1234_5678, WORD, one-cycle valid → next cycle `out_data=0x12345678`, `out_valid=1`, `out_err=0`.
  - src1=0x0000_80F0, `sel=1`:
    - BYTE_S `byte_off=0` → 0xFFFF_FFF0.
    - BYTE_U → 0x0000_00F0.
    - HALF_S `byte_off=0` → 0xFFFF_80F0.
    - HALF_U `byte_off=2` → 0x0000_0000.
- HALF_S with `byte_off=1` on 0xABCD_1234 → `out_data=0x0000_1234`, `out_err=1`.
- `NUM_SRC=6`, `sel=7` → `out_data=0`, `out_err=1`. `sel=5` → src5 with `out_err=0`.
- Back-pressure, words A,B,C,D on consecutive cycles, `out_ready` low on cycles 2–3:
  - `in_ready` low exactly while S full;
  - output sequence A,B,C,D, no loss or duplication;
  - data stable during stall.
- Assert reset mid-stall with M and S full → `out_valid=0`, `out_data=0`, `in_ready=0` immediately. After deassert, a new word E is output alone.
